branch_compare_unit: RTL

Multicycle operand comparator that produces the `igual`/`maior`/`menor` condition flags consumed by the branch-decision logic. It sits between the register-file read latches (A, B) and the branch mux. It compares two operands CHUNK bits per cycle, starting at the MSB, and stops early at the first differing chunk. It holds the resulting flags stable until the next accepted request.

---
 rtl/branch_compare_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/branch_compare_unit.sv
// rtl/branch_compare_unit.sv - multicycle chunked operand comparator for branch flags
//
// Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first,
// stopping at the first differing chunk. Signed compares are mapped onto
// unsigned order by inverting the sign bit of both operands at accept.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - request pulse, accepted only while idle
//   a, b       - operands, sampled on the accept edge
//   signed_cmp - 1 = two's-complement compare, 0 = unsigned
//   busy       - high while a compare is in flight (CMP or DONE)
//   done       - one-cycle pulse when new flags are written
//   igual      - A == B
//   maior      - A > B
//   menor      - A < B
module branch_compare_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_cmp,
    output logic             busy,
    output logic             done,
    output logic             igual,
    output logic             maior,
    output logic             menor
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH % CHUNK) != 0 || WIDTH < 2 || CHUNK < 1) begin : g_bad_params
        $error("branch_compare_unit: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  op_a, op_a_n;
    logic [WIDTH-1:0]  op_b, op_b_n;
    logic [IDXW-1:0]   idx, idx_n;
    logic              igual_n, maior_n, menor_n;

    // The operands are shifted left by one chunk after each equal chunk, so
    // the chunk under examination is always the top CHUNK bits. idx only
    // tracks how many chunks remain.
    logic [CHUNK-1:0]  chunk_a, chunk_b;

    assign chunk_a = op_a[WIDTH-1 -: CHUNK];
    assign chunk_b = op_b[WIDTH-1 -: CHUNK];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            idx   <= '0;
            igual <= 1'b0;
            maior <= 1'b0;
            menor <= 1'b0;
        end else begin
            state <= state_n;
            op_a  <= op_a_n;
            op_b  <= op_b_n;
            idx   <= idx_n;
            igual <= igual_n;
            maior <= maior_n;
            menor <= menor_n;
        end
    end

    always_comb begin
        state_n = state;
        op_a_n  = op_a;
        op_b_n  = op_b;
        idx_n   = idx;
        igual_n = igual;
        maior_n = maior;
        menor_n = menor;

        case (state)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit turns two's-complement order into
                    // unsigned order, so the chunk compare stays unsigned.
                    op_a_n  = {a[WIDTH-1] ^ signed_cmp, a[WIDTH-2:0]};
                    op_b_n  = {b[WIDTH-1] ^ signed_cmp, b[WIDTH-2:0]};
                    idx_n   = IDXW'(NCHUNK - 1);
                    state_n = CMP;
                end
            end
            CMP: begin
                if (chunk_a != chunk_b) begin
                    igual_n = 1'b0;
                    maior_n = (chunk_a > chunk_b);
                    menor_n = (chunk_a < chunk_b);
                    state_n = DONE;
                end else if (idx == '0) begin
                    igual_n = 1'b1;
                    maior_n = 1'b0;
                    menor_n = 1'b0;
                    state_n = DONE;
                end else begin
                    op_a_n = op_a << CHUNK;
                    op_b_n = op_b << CHUNK;
                    idx_n  = idx - IDXW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
